// File: rtl/versatile_io_wbm.sv
// Single-outstanding Wishbone B3 classic master: command in, one bus cycle, response out.
// Latency: bus strobe 1 cycle after accept, response 1 cycle after ack/err; define WBM_TIMEOUT_EN for a bus timeout.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready.
module versatile_io_wbm #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wbm_clk,
    input  logic        wbm_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
`ifdef WBM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    logic        accept;
    logic        misalign;
    logic [3:0]  sel_new;
    logic [31:0] wdat_new;
    logic [31:0] rd_ext;

    assign accept = cmd_valid && (state_q == IDLE);

    always_comb begin
        misalign = 1'b0;
        sel_new  = 4'b0000;
        wdat_new = 32'h0;
        case (cmd_size)
            SZ_BYTE: begin
                sel_new  = 4'b1000 >> cmd_adr[1:0];
                wdat_new = {4{cmd_dat[7:0]}};
            end
            SZ_HALF: begin
                misalign = cmd_adr[0];
                sel_new  = cmd_adr[1] ? 4'b0011 : 4'b1100;
                wdat_new = {2{cmd_dat[15:0]}};
            end
            SZ_WORD: begin
                misalign = (cmd_adr[1:0] != 2'b00);
                sel_new  = 4'b1111;
                wdat_new = cmd_dat;
            end
            default: misalign = 1'b1;
        endcase
    end

    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    always_comb begin
        rd_ext = 32'h0;
        case (size_q)
            SZ_BYTE: begin
                case (lo_q)
                    2'd0:    rd_ext = {24'h0, wbm_dat_i[31:24]};
                    2'd1:    rd_ext = {24'h0, wbm_dat_i[23:16]};
                    2'd2:    rd_ext = {24'h0, wbm_dat_i[15:8]};
                    default: rd_ext = {24'h0, wbm_dat_i[7:0]};
                endcase
            end
            SZ_HALF: rd_ext = {16'h0, lo_q[1] ? wbm_dat_i[15:0] : wbm_dat_i[31:16]};
            default: rd_ext = wbm_dat_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        size_d    = size_q;
        lo_d      = lo_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
`ifdef WBM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_dat_d = 32'h0;
                    if (misalign) begin
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d   = BUS;
                        rsp_err_d = 1'b0;
                        adr_d     = {cmd_adr[31:2], 2'b00};
                        wdat_d    = wdat_new;
                        sel_d     = sel_new;
                        we_d      = cmd_we;
                        size_d    = cmd_size;
                        lo_d      = cmd_adr[1:0];
`ifdef WBM_TIMEOUT_EN
                        cnt_d     = 16'h0;
`endif
                    end
                end
            end
            BUS: begin
                if (wbm_err_i) begin
                    state_d   = RESP;
                    rsp_err_d = 1'b1;
                    rsp_dat_d = 32'h0;
                end else if (wbm_ack_i) begin
                    state_d   = RESP;
                    rsp_err_d = 1'b0;
                    rsp_dat_d = we_q ? 32'h0 : rd_ext;
                end
`ifdef WBM_TIMEOUT_EN
                // Fires in the cycle the count reaches TIMEOUT, so stb is high exactly TIMEOUT cycles.
                else if (cnt_q == TMO_LAST) begin
                    state_d   = RESP;
                    rsp_err_d = 1'b1;
                    rsp_dat_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wbm_clk or negedge wbm_rst) begin
        if (!wbm_rst) begin
            state_q   <= IDLE;
            adr_q     <= 32'h0;
            wdat_q    <= 32'h0;
            sel_q     <= 4'h0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            lo_q      <= 2'b00;
            rsp_dat_q <= 32'h0;
            rsp_err_q <= 1'b0;
`ifdef WBM_TIMEOUT_EN
            cnt_q     <= 16'h0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            size_q    <= size_d;
            lo_q      <= lo_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
`ifdef WBM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = (state_q == BUS);
    assign wbm_stb_o = (state_q == BUS);
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = wdat_q;
    assign wbm_sel_o = sel_q;
    assign wbm_we_o  = we_q;

endmodule
